handshake_arb: RTL

Parametrised successor of the single-channel SPI handshake controller. It serves NUM_CH requesters, each raising its own ready. A round-robin arbiter picks one, issues a one-cycle start, and waits for done. It adds a transfer timeout, early-abort detection, a release phase and a transfer counter, and sits between the SPI slave front-end and the per-channel message buffers.

---
 rtl/hs_pkg.sv | 20 ++
 rtl/rr_arbiter.sv | 33 +++
 rtl/handshake_arb.sv | 129 ++++++++++++
 3 files changed

// File: rtl/hs_pkg.sv
// Shared types and width helpers for the multi-channel SPI handshake arbiter.
package hs_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ACTIVE  = 2'd1,
      RELEASE = 2'd2
   } hs_state_t;

   // Width of a channel index; a single channel still gets one bit.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Width of a timer that must hold 0..t; t=0 means the timer is unused.
   function automatic int tmr_w(input int t);
      return (t > 0) ? $clog2(t + 1) : 1;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request strictly after ptr, wrapping.
// Zero latency; no flow control of its own, the caller samples it only when idle.
module rr_arbiter
   import hs_pkg::*;
#(
   parameter  int NUM_CH = 4,
   localparam int IW     = idx_w(NUM_CH)
) (
   input  logic [NUM_CH-1:0] req,
   input  logic [IW-1:0]     ptr,
   output logic [NUM_CH-1:0] gnt_onehot,
   output logic [IW-1:0]     gnt_idx,
   output logic              any
);

   always_comb begin
      gnt_onehot = '0;
      gnt_idx    = '0;
      any        = 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
         int          pos;
         logic [IW-1:0] j;
         pos = (int'(ptr) + 1 + i) % NUM_CH;
         j   = IW'(pos);
         if (!any && req[j]) begin
            any           = 1'b1;
            gnt_idx       = j;
            gnt_onehot[j] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/handshake_arb.sv
// Round-robin handshake controller: grants one requester, pulses start, waits for done.
// Request-to-start is 1 cycle; a granted channel holds its grant until it releases ready.
module handshake_arb
   import hs_pkg::*;
#(
   parameter  int NUM_CH         = 4,
   parameter  int TIMEOUT_CYCLES = 1024,
   parameter  int CNT_W          = 8,
   localparam int IW             = idx_w(NUM_CH)
) (
   input  logic              clk,
   input  logic              rst_l,
   input  logic [NUM_CH-1:0] ready,
   input  logic              done,
   output logic              start,
   output logic [NUM_CH-1:0] grant,
   output logic [IW-1:0]     grant_idx,
   output logic              busy,
   output logic              timeout_err,
   output logic              abort,
   output logic [CNT_W-1:0]  xfer_cnt
);

   localparam int TW = tmr_w(TIMEOUT_CYCLES);

   hs_state_t         state, state_nx;
   logic [TW-1:0]     timer, timer_nx;
   logic [IW-1:0]     rr_ptr, rr_ptr_nx;
   logic [NUM_CH-1:0] grant_nx;
   logic [IW-1:0]     grant_idx_nx;
   logic              start_nx, timeout_nx, abort_nx;
   logic [CNT_W-1:0]  xfer_cnt_nx;

   logic [NUM_CH-1:0] arb_onehot;
   logic [IW-1:0]     arb_idx;
   logic              arb_any;

   rr_arbiter #(.NUM_CH(NUM_CH)) u_rr (
      .req        (ready),
      .ptr        (rr_ptr),
      .gnt_onehot (arb_onehot),
      .gnt_idx    (arb_idx),
      .any        (arb_any)
   );

   logic timer_hit;
   assign timer_hit = (TIMEOUT_CYCLES != 0) && (timer == TW'(TIMEOUT_CYCLES - 1));

   // Pulses are registered on the edge that leaves ACTIVE, so they line up
   // with the state change they report.
   always_comb begin
      state_nx     = state;
      timer_nx     = timer;
      rr_ptr_nx    = rr_ptr;
      grant_nx     = grant;
      grant_idx_nx = grant_idx;
      start_nx     = 1'b0;
      timeout_nx   = 1'b0;
      abort_nx     = 1'b0;
      xfer_cnt_nx  = xfer_cnt;
      unique case (state)
         IDLE: begin
            if (arb_any) begin
               state_nx     = ACTIVE;
               grant_nx     = arb_onehot;
               grant_idx_nx = arb_idx;
               start_nx     = 1'b1;
               timer_nx     = '0;
            end
         end
         ACTIVE: begin
            timer_nx = timer + TW'(1);
            if (done) begin
               xfer_cnt_nx = xfer_cnt + CNT_W'(1);
               state_nx    = RELEASE;
            end else if (!ready[grant_idx]) begin
               abort_nx     = 1'b1;
               state_nx     = IDLE;
               rr_ptr_nx    = grant_idx;
               grant_nx     = '0;
               grant_idx_nx = '0;
            end else if (timer_hit) begin
               timeout_nx = 1'b1;
               state_nx   = RELEASE;
            end
         end
         RELEASE: begin
            if (!ready[grant_idx] && !done) begin
               state_nx     = IDLE;
               rr_ptr_nx    = grant_idx;
               grant_nx     = '0;
               grant_idx_nx = '0;
            end
         end
         default: begin
            state_nx     = IDLE;
            grant_nx     = '0;
            grant_idx_nx = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_l) begin
         state       <= IDLE;
         timer       <= '0;
         rr_ptr      <= IW'(NUM_CH - 1);
         grant       <= '0;
         grant_idx   <= '0;
         start       <= 1'b0;
         busy        <= 1'b0;
         timeout_err <= 1'b0;
         abort       <= 1'b0;
         xfer_cnt    <= '0;
      end else begin
         state       <= state_nx;
         timer       <= timer_nx;
         rr_ptr      <= rr_ptr_nx;
         grant       <= grant_nx;
         grant_idx   <= grant_idx_nx;
         start       <= start_nx;
         busy        <= (state_nx != IDLE);
         timeout_err <= timeout_nx;
         abort       <= abort_nx;
         xfer_cnt    <= xfer_cnt_nx;
      end
   end

endmodule
